reserved_parking_exit: RTL and testbench

Exit-side controller for the reserved (PWD) parking slots: owns the registered occupancy vector for flats 1..N+1, accepts occupancy marks from the entry path, and serves exit requests through a request/ack handshake. A granted exit frees the slot and drives the exit barrier open for a fixed number of cycles; a refused exit returns an error code. It sits beside the reserved entry logic and is the single owner of reserved-slot occupancy state.

---
 rtl/reserved_parking_exit_if.sv | 33 +++
 rtl/reserved_parking_exit.sv | 157 +++++++++++++++
 tb/tb_reserved_parking_exit.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/reserved_parking_exit_if.sv
// Exit-side bus of the reserved parking controller: occupancy marks from the entry
// path, the exit request/ack handshake, gate/status outputs and the occupancy view.
interface reserved_parking_exit_if #(
  parameter int unsigned N = 8
);
  localparam int unsigned W  = $clog2(N) + 1;
  localparam int unsigned CW = $clog2(N + 2);

  logic          occ_set_valid;
  logic [W-1:0]  occ_set_flat;
  logic          exit_req;
  logic          exit_pwd;
  logic [W-1:0]  exit_flat;
  logic          exit_ack;
  logic          exit_ok;
  logic [1:0]    exit_err;
  logic          gate_open;
  logic          busy;
  logic [N:0]    occ_vec;
  logic [CW-1:0] free_count;

  // Requester / entry-path side.
  modport master (
    output occ_set_valid, occ_set_flat, exit_req, exit_pwd, exit_flat,
    input  exit_ack, exit_ok, exit_err, gate_open, busy, occ_vec, free_count
  );

  // Controller side.
  modport slave (
    input  occ_set_valid, occ_set_flat, exit_req, exit_pwd, exit_flat,
    output exit_ack, exit_ok, exit_err, gate_open, busy, occ_vec, free_count
  );
endinterface

// File: rtl/reserved_parking_exit.sv
// Reserved (PWD) parking exit controller. Single owner of the reserved-slot occupancy
// vector: marks slots occupied from the entry path, decides exit requests, frees the
// slot on a grant and holds the exit barrier open for GATE_CYCLES cycles.
module reserved_parking_exit #(
  parameter int unsigned N           = 8,
  parameter int unsigned GATE_CYCLES = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  reserved_parking_exit_if.slave bus
);
  localparam int unsigned W   = $clog2(N) + 1;
  localparam int unsigned CW  = $clog2(N + 2);
  localparam int unsigned GCW = $clog2(GATE_CYCLES + 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StCheck = 2'd1;
  localparam logic [1:0] StOpen  = 2'd2;

  localparam logic [1:0] ErrNone  = 2'd0;
  localparam logic [1:0] ErrFlat  = 2'd1;
  localparam logic [1:0] ErrPwd   = 2'd2;
  localparam logic [1:0] ErrEmpty = 2'd3;

  logic [1:0]     state_q, state_d;
  logic [W-1:0]   flat_q, flat_d;
  logic           pwd_q, pwd_d;
  logic [GCW-1:0] cnt_q, cnt_d;
  logic [N:0]     occ_q, occ_d;
  logic [CW-1:0]  free_q, free_d;
  logic           ack_q, ack_d;
  logic           ok_q, ok_d;
  logic [1:0]     err_q, err_d;

  logic [N:0]     set_mask;
  logic [N:0]     exit_match;
  logic [N:0]     clr_mask;
  logic           flat_valid;
  logic           slot_occ;

  // Decode flat numbers into one-hot slot masks; no match means the flat is out of range.
  always_comb begin
    set_mask   = '0;
    exit_match = '0;
    for (int k = 0; k <= int'(N); k++) begin
      set_mask[k]   = bus.occ_set_valid && (bus.occ_set_flat == W'(k + 1));
      exit_match[k] = (flat_q == W'(k + 1));
    end
    flat_valid = |exit_match;
    slot_occ   = |(occ_q & exit_match);
  end

  // Request FSM: latch in IDLE, decide in CHECK, time the barrier in OPEN.
  always_comb begin
    state_d  = state_q;
    flat_d   = flat_q;
    pwd_d    = pwd_q;
    cnt_d    = cnt_q;
    ack_d    = 1'b0;
    ok_d     = ok_q;
    err_d    = err_q;
    clr_mask = '0;
    case (state_q)
      StIdle: begin
        if (bus.exit_req) begin
          flat_d  = bus.exit_flat;
          pwd_d   = bus.exit_pwd;
          state_d = StCheck;
        end
      end
      StCheck: begin
        ack_d   = 1'b1;
        state_d = StIdle;
        if (!flat_valid) begin
          ok_d  = 1'b0;
          err_d = ErrFlat;
        end else if (!pwd_q) begin
          ok_d  = 1'b0;
          err_d = ErrPwd;
        end else if (!slot_occ) begin
          ok_d  = 1'b0;
          err_d = ErrEmpty;
        end else begin
          ok_d     = 1'b1;
          err_d    = ErrNone;
          clr_mask = exit_match;
          cnt_d    = GCW'(GATE_CYCLES);
          state_d  = StOpen;
        end
      end
      StOpen: begin
        if (cnt_q <= GCW'(1)) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - GCW'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  // Occupancy update: a set landing on the slot being freed wins; count zeros of the result.
  always_comb begin
    occ_d  = (occ_q & ~clr_mask) | set_mask;
    free_d = '0;
    for (int k = 0; k <= int'(N); k++) begin
      if (!occ_d[k]) begin
        free_d = free_d + CW'(1);
      end
    end
  end

  // State registers, asynchronously cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      flat_q  <= '0;
      pwd_q   <= 1'b0;
      cnt_q   <= '0;
      occ_q   <= '0;
      free_q  <= CW'(N + 1);
      ack_q   <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= ErrNone;
    end else begin
      state_q <= state_d;
      flat_q  <= flat_d;
      pwd_q   <= pwd_d;
      cnt_q   <= cnt_d;
      occ_q   <= occ_d;
      free_q  <= free_d;
      ack_q   <= ack_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  assign bus.exit_ack   = ack_q;
  assign bus.exit_ok    = ok_q;
  assign bus.exit_err   = err_q;
  assign bus.gate_open  = (state_q == StOpen);
  assign bus.busy       = (state_q != StIdle);
  assign bus.occ_vec    = occ_q;
  assign bus.free_count = free_q;

  // The free counter must always agree with the occupancy vector.
  a_free_consistent: assert property (@(posedge clk) disable iff (!rst_n)
    (32'(free_q) + $countones(occ_q)) == (N + 1));

  // An ack can only follow a CHECK cycle.
  a_ack_after_check: assert property (@(posedge clk) disable iff (!rst_n)
    ack_q |-> ($past(state_q) == StCheck));
endmodule

// File: tb/tb_reserved_parking_exit.sv
// Scoreboard bench for reserved_parking_exit: stimulus pushes the expected decision of
// each exit request; a monitor pops and compares whenever exit_ack pulses.
module tb_reserved_parking_exit;
  localparam int unsigned N    = 8;
  localparam int unsigned GATE = 4;
  localparam int unsigned W    = $clog2(N) + 1;
  localparam int unsigned CW   = $clog2(N + 2);

  typedef struct {
    logic          ok;
    logic [1:0]    err;
    logic [N:0]    occ;
    logic [CW-1:0] free;
    string         name;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  reserved_parking_exit_if #(.N(N)) bus ();

  reserved_parking_exit #(
    .N           (N),
    .GATE_CYCLES (GATE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every ack must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.exit_ack) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected ack: got ack with empty scoreboard expected none");
        end else begin
          e = sb.pop_front();
          check({e.name, " exit_ok"}, 32'(bus.exit_ok), 32'(e.ok));
          check({e.name, " exit_err"}, 32'(bus.exit_err), 32'(e.err));
          check({e.name, " occ_vec"}, 32'(bus.occ_vec), 32'(e.occ));
          check({e.name, " free_count"}, 32'(bus.free_count), 32'(e.free));
        end
      end
    end
  end

  task automatic set_occ(input logic [W-1:0] flat, input logic [N:0] exp_occ,
                         input logic [CW-1:0] exp_free);
    @(negedge clk);
    bus.occ_set_valid = 1'b1;
    bus.occ_set_flat  = flat;
    @(negedge clk);
    bus.occ_set_valid = 1'b0;
    check($sformatf("set flat %0d occ_vec", flat), 32'(bus.occ_vec), 32'(exp_occ));
    check($sformatf("set flat %0d free_count", flat), 32'(bus.free_count), 32'(exp_free));
  endtask

  // Request already driven; returns at the negedge where exit_ack is seen.
  task automatic wait_ack(input string name, input int exp_lat, output bit got);
    int lat;
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) check({name, " busy after sample"}, 32'(bus.busy), 32'd1);
      if (bus.exit_ack) begin
        got = 1'b1;
        break;
      end
    end
    if (got) check({name, " ack latency"}, 32'(lat), 32'(exp_lat));
    else check({name, " ack timeout"}, 32'd0, 32'd1);
  endtask

  // Called in the ack cycle: drop the request, check the pulse and barrier window.
  task automatic finish_ack(input string name, input int exp_gate);
    int g;
    g = bus.gate_open ? 1 : 0;
    bus.exit_req = 1'b0;
    @(negedge clk);
    check({name, " ack pulse width"}, 32'(bus.exit_ack), 32'd0);
    for (int i = 0; i < 20 && bus.gate_open; i++) begin
      g++;
      @(negedge clk);
    end
    check({name, " gate cycles"}, 32'(g), 32'(exp_gate));
    check({name, " busy released"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic do_exit(input string name, input logic [W-1:0] flat, input logic pwd,
                         input logic ok, input logic [1:0] err, input logic [N:0] occ,
                         input logic [CW-1:0] free);
    bit got;
    @(negedge clk);
    bus.exit_req  = 1'b1;
    bus.exit_flat = flat;
    bus.exit_pwd  = pwd;
    sb.push_back('{ok, err, occ, free, name});
    wait_ack(name, 2, got);
    if (got) finish_ack(name, ok ? int'(GATE) : 0);
    else bus.exit_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit got;
    int g;
    int lat;
    rst_n             = 1'b0;
    bus.occ_set_valid = 1'b0;
    bus.occ_set_flat  = '0;
    bus.exit_req      = 1'b0;
    bus.exit_pwd      = 1'b0;
    bus.exit_flat     = '0;
    repeat (3) @(negedge clk);
    check("reset occ_vec", 32'(bus.occ_vec), 32'd0);
    check("reset free_count", 32'(bus.free_count), 32'd9);
    check("reset exit_ack", 32'(bus.exit_ack), 32'd0);
    check("reset exit_ok", 32'(bus.exit_ok), 32'd0);
    check("reset exit_err", 32'(bus.exit_err), 32'd0);
    check("reset gate_open", 32'(bus.gate_open), 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;

    // Basic grant.
    set_occ(4'd3, 9'b000000100, 4'd8);
    do_exit("grant flat3", 4'd3, 1'b1, 1'b1, 2'd0, 9'b0, 4'd9);

    // Refusals and boundaries.
    do_exit("empty flat5", 4'd5, 1'b1, 1'b0, 2'd3, 9'b0, 4'd9);
    do_exit("flat0", 4'd0, 1'b1, 1'b0, 2'd1, 9'b0, 4'd9);
    do_exit("flat10", 4'd10, 1'b1, 1'b0, 2'd1, 9'b0, 4'd9);
    do_exit("flat0 nopwd", 4'd0, 1'b0, 1'b0, 2'd1, 9'b0, 4'd9);
    do_exit("empty flat9", 4'd9, 1'b1, 1'b0, 2'd3, 9'b0, 4'd9);
    set_occ(4'd0, 9'b0, 4'd9);
    set_occ(4'd10, 9'b0, 4'd9);

    // Not PWD: occupancy untouched, error sticky.
    set_occ(4'd2, 9'b000000010, 4'd8);
    do_exit("nopwd flat2", 4'd2, 1'b0, 1'b0, 2'd2, 9'b000000010, 4'd8);
    repeat (3) @(negedge clk);
    check("sticky exit_err", 32'(bus.exit_err), 32'd2);

    // Set during CHECK of the granted flat wins; second request waits for IDLE.
    set_occ(4'd4, 9'b000001010, 4'd7);
    @(negedge clk);
    bus.exit_req  = 1'b1;
    bus.exit_flat = 4'd4;
    bus.exit_pwd  = 1'b1;
    sb.push_back('{1'b1, 2'd0, 9'b000001010, 4'd7, "grant flat4 with set"});
    @(negedge clk);
    check("flat4 busy in check", 32'(bus.busy), 32'd1);
    bus.occ_set_valid = 1'b1;
    bus.occ_set_flat  = 4'd4;
    @(negedge clk);
    bus.occ_set_valid = 1'b0;
    check("flat4 ack", 32'(bus.exit_ack), 32'd1);
    g = bus.gate_open ? 1 : 0;
    bus.exit_req = 1'b0;
    @(negedge clk);
    bus.exit_req  = 1'b1;
    bus.exit_flat = 4'd2;
    bus.exit_pwd  = 1'b1;
    sb.push_back('{1'b1, 2'd0, 9'b000001000, 4'd8, "grant flat2 queued"});
    if (bus.gate_open) g++;
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (bus.exit_ack) begin
        got = 1'b1;
        break;
      end
      if (bus.gate_open) g++;
    end
    check("flat4 gate cycles", 32'(g), 32'(GATE));
    check("flat2 waits for idle", 32'(lat), 32'd5);
    if (got) finish_ack("grant flat2 queued", int'(GATE));
    else bus.exit_req = 1'b0;

    // Reset in the second cycle of OPEN.
    set_occ(4'd6, 9'b000101000, 4'd7);
    @(negedge clk);
    bus.exit_req  = 1'b1;
    bus.exit_flat = 4'd6;
    bus.exit_pwd  = 1'b1;
    sb.push_back('{1'b1, 2'd0, 9'b000001000, 4'd8, "grant flat6"});
    wait_ack("grant flat6", 2, got);
    bus.exit_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midopen gate_open", 32'(bus.gate_open), 32'd0);
    check("midopen busy", 32'(bus.busy), 32'd0);
    check("midopen exit_ok", 32'(bus.exit_ok), 32'd0);
    check("midopen occ_vec", 32'(bus.occ_vec), 32'd0);
    check("midopen free_count", 32'(bus.free_count), 32'd9);
    @(negedge clk);
    rst_n = 1'b1;

    set_occ(4'd9, 9'b100000000, 4'd8);
    do_exit("grant flat9", 4'd9, 1'b1, 1'b1, 2'd0, 9'b0, 4'd9);

    repeat (2) @(negedge clk);
    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
